board_draw_sched: RTL and testbench

- Sequences the 12x12 tile plotter to paint the 8x8 Othello board.
- Arbitrates between two requesters: full-board redraw and single-cell update.
- For each cell: reads its state from board RAM, maps it to a picture select, computes the tile origin, starts the plotter and waits for completion.
- Optionally draws the cursor outline as a second, overlaid tile.

---
 rtl/board_draw_sched.sv | 180 ++++++++++++++++++
 tb/tb_board_draw_sched.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/board_draw_sched.sv
// rtl/board_draw_sched.sv - sequences the tile plotter over the 8x8 Othello board
// Define CURSOR_OVERLAY_EN to overlay the cursor outline tile on the cursor cell.
module board_draw_sched #(
    parameter int         TILE = 12,
    parameter logic [7:0] X0   = 8'd16,
    parameter logic [6:0] Y0   = 7'd12
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       redraw_req,
    input  logic       cell_req,
    input  logic [2:0] cell_row,
    input  logic [2:0] cell_col,
    input  logic [2:0] cursor_row,
    input  logic [2:0] cursor_col,
    output logic [5:0] board_addr,
    input  logic [1:0] board_data,
    output logic       tile_start,
    output logic [7:0] tile_x,
    output logic [6:0] tile_y,
    output logic [1:0] tile_select,
    input  logic       tile_done,
    output logic       busy,
    output logic       frame_done
);
    localparam logic [7:0] TILE8 = 8'(TILE);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_FETCH    = 3'd1,
        S_DATA     = 3'd2,
        S_START    = 3'd3,
        S_WAIT     = 3'd4,
        S_NEXT     = 3'd5
`ifdef CURSOR_OVERLAY_EN
        ,
        S_OVL      = 3'd6,
        S_OVL_WAIT = 3'd7
`endif
    } state_t;

    state_t     r_state;
    state_t     w_next_state;
    logic       r_pend_full;
    logic       r_pend_cell;
    logic [2:0] r_cap_row;
    logic [2:0] r_cap_col;
    logic [2:0] r_row;
    logic [2:0] r_col;
    logic       r_full_job;
    logic [7:0] r_x;
    logic [6:0] r_y;
    logic [1:0] r_sel;

    logic       w_accept_full;
    logic       w_accept_cell;
    logic       w_last;
    logic [7:0] w_col_px;
    logic [7:0] w_row_px;
    logic [7:0] w_x;
    logic [7:0] w_y_sum;
    logic [1:0] w_sel_map;
    logic       w_unused_bits;

    // Full redraw outranks a cell update and makes the pending cell redundant.
    assign w_accept_full = (r_state == S_IDLE) && r_pend_full;
    assign w_accept_cell = (r_state == S_IDLE) && !r_pend_full && r_pend_cell;
    assign w_last        = r_full_job ? ({r_row, r_col} == 6'h3f) : 1'b1;

    assign w_col_px = {5'd0, r_col} * TILE8;
    assign w_row_px = {5'd0, r_row} * TILE8;
    assign w_x      = X0 + w_col_px;
    assign w_y_sum  = {1'b0, Y0} + w_row_px;
    assign w_unused_bits = w_y_sum[7] ^ (^{cursor_row, cursor_col});

    always_comb begin
        w_sel_map = 2'd0;
        case (board_data)
            2'b01:   w_sel_map = 2'd2;
            2'b10:   w_sel_map = 2'd3;
            default: w_sel_map = 2'd0;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state     <= S_IDLE;
            r_pend_full <= 1'b0;
            r_pend_cell <= 1'b0;
            r_cap_row   <= 3'd0;
            r_cap_col   <= 3'd0;
            r_row       <= 3'd0;
            r_col       <= 3'd0;
            r_full_job  <= 1'b0;
            r_x         <= 8'd0;
            r_y         <= 7'd0;
            r_sel       <= 2'd0;
        end else begin
            r_state     <= w_next_state;
            r_pend_full <= (r_pend_full & ~w_accept_full) | redraw_req;
            r_pend_cell <= (r_pend_cell & ~(w_accept_full | w_accept_cell)) | cell_req;
            if (cell_req) begin
                r_cap_row <= cell_row;
                r_cap_col <= cell_col;
            end
            if (w_accept_full) begin
                r_full_job <= 1'b1;
                r_row      <= 3'd0;
                r_col      <= 3'd0;
            end else if (w_accept_cell) begin
                r_full_job <= 1'b0;
                r_row      <= r_cap_row;
                r_col      <= r_cap_col;
            end else if (r_state == S_NEXT && !w_last) begin
                {r_row, r_col} <= {r_row, r_col} + 6'd1;
            end
            if (r_state == S_DATA) begin
                r_x   <= w_x;
                r_y   <= w_y_sum[6:0];
                r_sel <= w_sel_map;
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        tile_start   = 1'b0;
        frame_done   = 1'b0;
        case (r_state)
            S_IDLE:  if (r_pend_full || r_pend_cell) w_next_state = S_FETCH;
            S_FETCH: w_next_state = S_DATA;
            S_DATA:  w_next_state = S_START;
            S_START: begin
                tile_start   = 1'b1;
                w_next_state = S_WAIT;
            end
            S_WAIT: begin
                if (tile_done) begin
`ifdef CURSOR_OVERLAY_EN
                    if ({r_row, r_col} == {cursor_row, cursor_col})
                        w_next_state = S_OVL;
                    else
                        w_next_state = S_NEXT;
`else
                    w_next_state = S_NEXT;
`endif
                end
            end
`ifdef CURSOR_OVERLAY_EN
            S_OVL: begin
                tile_start   = 1'b1;
                w_next_state = S_OVL_WAIT;
            end
            S_OVL_WAIT: if (tile_done) w_next_state = S_NEXT;
`endif
            S_NEXT: begin
                if (w_last) begin
                    frame_done   = 1'b1;
                    w_next_state = S_IDLE;
                end else begin
                    w_next_state = S_FETCH;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        tile_select = r_sel;
`ifdef CURSOR_OVERLAY_EN
        if (r_state == S_OVL || r_state == S_OVL_WAIT) tile_select = 2'd1;
`endif
    end

    assign board_addr = {r_row, r_col};
    assign tile_x     = r_x;
    assign tile_y     = r_y;
    assign busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_board_draw_sched.sv
// tb/tb_board_draw_sched.sv - self-checking bench for board_draw_sched
module tb_board_draw_sched;
    logic       clock = 1'b0;
    logic       resetn;
    logic       redraw_req, cell_req;
    logic [2:0] cell_row, cell_col, cursor_row, cursor_col;
    logic [5:0] board_addr;
    logic [1:0] board_data;
    logic       tile_start;
    logic [7:0] tile_x;
    logic [6:0] tile_y;
    logic [1:0] tile_select;
    logic       tile_done, busy, frame_done;

    always #5 clock = ~clock;

    board_draw_sched dut (
        .clock(clock), .resetn(resetn), .redraw_req(redraw_req), .cell_req(cell_req),
        .cell_row(cell_row), .cell_col(cell_col), .cursor_row(cursor_row), .cursor_col(cursor_col),
        .board_addr(board_addr), .board_data(board_data), .tile_start(tile_start),
        .tile_x(tile_x), .tile_y(tile_y), .tile_select(tile_select), .tile_done(tile_done),
        .busy(busy), .frame_done(frame_done)
    );

    logic [1:0] mem [64];
    always @(posedge clock) board_data <= mem[board_addr];

    typedef struct { int x; int y; int sel; int t; } start_t;
    typedef struct { int row; int col; int data; int ex; int ey; int esel; } vec_t;

    start_t obs_q[$];
    start_t exp_q[$];
    vec_t   vt[6];
    int vectors = 0, miscompares = 0;
    int cyc = 0, obs_frames = 0, last_frame_cyc = 0;
    int pl_cnt = 0, pl_delay = 1;
    bit auto_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: actual %0h required %0h", name, act, req);
        end
    endtask

    // One clock: observe outputs at the falling edge, then drive the next inputs.
    task automatic tick();
        start_t s;
        @(negedge clock);
        cyc++;
        if (tile_start === 1'b1) begin
            s.x = int'(tile_x); s.y = int'(tile_y); s.sel = int'(tile_select); s.t = cyc;
            obs_q.push_back(s);
        end
        if (frame_done === 1'b1) begin
            obs_frames++;
            last_frame_cyc = cyc;
        end
        redraw_req = 1'b0;
        cell_req   = 1'b0;
        tile_done  = 1'b0;
        if (pl_cnt > 0) begin
            pl_cnt--;
            if (pl_cnt == 0) tile_done = 1'b1;
        end
        if (auto_en && tile_start === 1'b1) pl_cnt = pl_delay;
    endtask

    function automatic int map_sel(input logic [1:0] d);
        case (d)
            2'b01:   return 2;
            2'b10:   return 3;
            default: return 0;
        endcase
    endfunction

    task automatic push_tile(input int r, input int c);
        start_t e;
        e.x = (16 + 12 * c) % 256;
        e.y = (12 + 12 * r) % 128;
        e.sel = map_sel(mem[r * 8 + c]);
        e.t = 0;
        exp_q.push_back(e);
`ifdef CURSOR_OVERLAY_EN
        if (r == int'(cursor_row) && c == int'(cursor_col)) begin
            e.sel = 1;
            exp_q.push_back(e);
        end
`endif
    endtask

    task automatic push_job(input bit full, input int r, input int c);
        if (full) begin
            for (int rr = 0; rr < 8; rr++)
                for (int cc = 0; cc < 8; cc++) push_tile(rr, cc);
        end else begin
            push_tile(r, c);
        end
    endtask

    function automatic logic [31:0] pack(input start_t s);
        return 32'((s.x << 16) | (s.y << 8) | s.sel);
    endfunction

    task automatic compare_q(input string name);
        chk({name, " start count"}, obs_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
            chk({name, " tile x/y/sel"}, pack(obs_q[i]), pack(exp_q[i]));
    endtask

    task automatic wait_frames(input int n, input int budget, input string name);
        int t = 0;
        while (obs_frames < n && t < budget) begin
            tick();
            t++;
        end
        chk({name, " frame_done within budget"}, 32'(obs_frames >= n), 1);
    endtask

    task automatic req_cell(input int r, input int c);
        cell_row = 3'(r);
        cell_col = 3'(c);
        cell_req = 1'b1;
    endtask

    initial begin
        int f0, kind, extra, njobs, ar, ac, br, bc, t;
        vt[0] = '{2, 5, 1, 76, 36, 2};
        vt[1] = '{0, 0, 0, 16, 12, 0};
        vt[2] = '{7, 7, 3, 100, 96, 0};
        vt[3] = '{0, 7, 2, 100, 12, 3};
        vt[4] = '{7, 0, 1, 16, 96, 2};
        vt[5] = '{3, 4, 2, 64, 48, 3};

        resetn = 1'b0; redraw_req = 1'b0; cell_req = 1'b0; tile_done = 1'b0;
        cell_row = 3'd0; cell_col = 3'd0; cursor_row = 3'd6; cursor_col = 3'd6;
        for (int i = 0; i < 64; i++) mem[i] = 2'(i % 4);

        repeat (3) tick();
        chk("reset board_addr", board_addr, 0);
        chk("reset tile_start", tile_start, 0);
        chk("reset tile_x", tile_x, 0);
        chk("reset tile_y", tile_y, 0);
        chk("reset tile_select", tile_select, 0);
        chk("reset busy", busy, 0);
        chk("reset frame_done", frame_done, 0);
        resetn = 1'b1;
        repeat (3) tick();
        chk("idle busy", busy, 0);
        chk("idle starts", obs_q.size(), 0);

        // Single-cell vectors with exact cycle-by-cycle timing.
        for (int v = 0; v < 6; v++) begin
            mem[vt[v].row * 8 + vt[v].col] = 2'(vt[v].data);
            obs_q.delete();
            f0 = obs_frames;
            req_cell(vt[v].row, vt[v].col);
            tick();
            chk("vec accept busy", busy, 0);
            tick();
            chk("vec fetch addr", board_addr, 32'(vt[v].row * 8 + vt[v].col));
            chk("vec fetch busy", busy, 1);
            tick();
            tick();
            chk("vec start latency", obs_q.size(), 1);
            chk("vec tile_x", tile_x, vt[v].ex);
            chk("vec tile_y", tile_y, vt[v].ey);
            chk("vec tile_select", tile_select, vt[v].esel);
            tick();
            chk("vec wait start low", tile_start, 0);
            chk("vec wait x held", tile_x, vt[v].ex);
            tile_done = 1'b1;
            tick();
            chk("vec frame_done", frame_done, 1);
            tick();
            chk("vec busy after", busy, 0);
            chk("vec frames", obs_frames - f0, 1);
        end

        // Reset while waiting on the plotter abandons the job.
        req_cell(1, 2);
        repeat (5) tick();
        resetn = 1'b0;
        #1;
        chk("midreset busy", busy, 0);
        chk("midreset tile_x", tile_x, 0);
        chk("midreset tile_y", tile_y, 0);
        chk("midreset tile_select", tile_select, 0);
        chk("midreset tile_start", tile_start, 0);
        obs_q.delete();
        f0 = obs_frames;
        tile_done = 1'b1;
        tick();
        resetn = 1'b1;
        repeat (10) tick();
        chk("midreset no frame", obs_frames - f0, 0);
        chk("midreset no start", obs_q.size(), 0);
        chk("midreset idle", busy, 0);

        // Stray tile_done outside WAIT must not complete the tile.
        mem[9] = 2'b10;
        obs_q.delete();
        f0 = obs_frames;
        req_cell(1, 1);
        tick();
        tick(); tile_done = 1'b1;
        tick(); tile_done = 1'b1;
        tick(); tile_done = 1'b1;
        chk("stray start", obs_q.size(), 1);
        repeat (3) tick();
        chk("stray still busy", busy, 1);
        chk("stray no frame", obs_frames - f0, 0);
        tile_done = 1'b1;
        tick();
        chk("stray frame_done", frame_done, 1);
        tick();
        chk("stray idle", busy, 0);

        // Last cell_req wins while busy.
        mem[0] = 2'b01; mem[27] = 2'b10; mem[36] = 2'b01;
        obs_q.delete(); exp_q.delete();
        f0 = obs_frames;
        req_cell(0, 0);
        repeat (5) tick();
        req_cell(3, 3);
        tick();
        req_cell(4, 4);
        tick();
        auto_en = 1'b1; pl_delay = 2;
        tile_done = 1'b1;
        wait_frames(f0 + 2, 100, "overwrite");
        repeat (10) tick();
        push_job(1'b0, 0, 0);
        push_job(1'b0, 4, 4);
        compare_q("overwrite");
        chk("overwrite frames", obs_frames - f0, 2);

        // Full redraw with a same-cycle cell request.
        for (int i = 0; i < 64; i++) mem[i] = 2'(i % 4);
        obs_q.delete(); exp_q.delete();
        f0 = obs_frames;
        pl_delay = 1;
        req_cell(1, 1);
        redraw_req = 1'b1;
        wait_frames(f0 + 1, 1500, "redraw");
        repeat (20) tick();
        push_job(1'b1, 0, 0);
        compare_q("redraw");
        chk("redraw frames", obs_frames - f0, 1);
        if (obs_q.size() >= 2) begin
            chk("redraw last x", obs_q[obs_q.size() - 1].x, 100);
            chk("redraw last y", obs_q[obs_q.size() - 1].y, 96);
            chk("redraw start spacing", obs_q[1].t - obs_q[0].t, 5);
        end

        // Cursor cell: overlay tile when enabled, otherwise a single tile.
        cursor_row = 3'd0; cursor_col = 3'd0;
        mem[0] = 2'b10;
        obs_q.delete(); exp_q.delete();
        f0 = obs_frames;
        pl_delay = 2;
        req_cell(0, 0);
        wait_frames(f0 + 1, 60, "cursor");
        repeat (5) tick();
        push_job(1'b0, 0, 0);
        compare_q("cursor");
        chk("cursor frames", obs_frames - f0, 1);
        if (obs_q.size() >= 1)
            chk("cursor frame after last done", last_frame_cyc - obs_q[obs_q.size() - 1].t, 3);

        // Randomised rounds against the job-level model.
        for (int rd = 0; rd < 12; rd++) begin
            for (int i = 0; i < 64; i++) mem[i] = 2'($urandom_range(0, 3));
            cursor_row = 3'($urandom_range(0, 7));
            cursor_col = 3'($urandom_range(0, 7));
            pl_delay = int'($urandom_range(1, 4));
            kind  = int'($urandom_range(0, 5));
            extra = int'($urandom_range(0, 5));
            ar = int'($urandom_range(0, 7)); ac = int'($urandom_range(0, 7));
            br = int'($urandom_range(0, 7)); bc = int'($urandom_range(0, 7));
            obs_q.delete(); exp_q.delete();
            f0 = obs_frames;
            njobs = 1;
            if (kind != 4) req_cell(ar, ac);
            if (kind >= 4) redraw_req = 1'b1;
            push_job(kind >= 4, ar, ac);
            t = 0;
            while (obs_q.size() == 0 && t < 10) begin
                tick();
                t++;
            end
            if (extra >= 1 && extra <= 4) begin
                njobs = 2;
                req_cell(br, bc);
                if (extra == 4) redraw_req = 1'b1;
                tick();
                if (extra == 2) begin
                    br = int'($urandom_range(0, 7)); bc = int'($urandom_range(0, 7));
                    req_cell(br, bc);
                end
                if (extra == 3) redraw_req = 1'b1;
                tick();
                push_job(extra >= 3, br, bc);
            end
            wait_frames(f0 + njobs, 2000, "random");
            repeat (6) tick();
            chk("random frames", obs_frames - f0, njobs);
            compare_q("random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
